// File: rtl/selftrigger_channel_arbiter.sv
// Self-trigger channel arbiter: edge-detects per-channel triggers, timestamps accepted
// edges under a per-channel holdoff, and serialises pending events round-robin onto one port.
module selftrigger_channel_arbiter #(
    parameter int NCH     = 8,
    parameter int CH_W    = 3,
    parameter int TS_W    = 64,
    parameter int HOLDOFF = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [NCH-1:0]    ch_mask,
    input  logic [NCH-1:0]    trigger,
    input  logic [TS_W-1:0]   timestamp,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [CH_W-1:0]   ev_channel,
    output logic [TS_W-1:0]   ev_timestamp,
    output logic [NCH-1:0]    pending,
    output logic [15:0]       drop_count
);

    localparam int HO_W = $clog2(HOLDOFF);
    localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HOLDOFF - 1);

    typedef enum logic {
        S_IDLE,
        S_PRESENT
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NCH-1:0]    r_trig_d;
    logic [NCH-1:0]    r_pending;
    logic [HO_W-1:0]   r_hold [NCH];
    logic [TS_W-1:0]   r_ts   [NCH];
    logic [CH_W-1:0]   r_ev_channel;
    logic [TS_W-1:0]   r_ev_ts;
    logic [CH_W-1:0]   r_last_grant;
    logic [15:0]       r_drop_cnt;

    logic [NCH-1:0]    w_edge;
    logic [NCH-1:0]    w_hold_zero;
    logic [NCH-1:0]    w_acc;
    logic [NCH-1:0]    w_take;
    logic [NCH-1:0]    w_drop;
    logic [NCH-1:0]    w_grant_vec;
    logic [NCH-1:0]    w_pending_nxt;
    logic [CH_W-1:0]   w_sel;
    logic              w_any;
    logic              w_grant;
    logic              w_hs;

    function automatic logic [CH_W-1:0] rr_index(input logic [CH_W-1:0] base, input int k);
        int j;
        j = int'(base) + k;
        if (j >= NCH) j = j - NCH;
        return CH_W'(j);
    endfunction

    // Several channels can drop on the same edge; each lost trigger counts once.
    function automatic logic [15:0] sat_add_drops(input logic [15:0] cnt, input logic [NCH-1:0] drops);
        int s;
        s = int'(cnt);
        for (int i = 0; i < NCH; i++) begin
            if (drops[i]) s = s + 1;
        end
        if (s > 65535) s = 65535;
        return 16'(s);
    endfunction

    always_comb begin
        w_sel = '0;
        w_any = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
            if (!w_any && r_pending[rr_index(r_last_grant, k)]) begin
                w_sel = rr_index(r_last_grant, k);
                w_any = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_hs        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (ev_ready) begin
                    w_hs        = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A channel granted this cycle may accept a new trigger; the new set overrides the clear.
    always_comb begin
        w_grant_vec = '0;
        if (w_grant) w_grant_vec[w_sel] = 1'b1;
        w_edge = trigger & ~r_trig_d;
        for (int i = 0; i < NCH; i++) begin
            w_hold_zero[i] = (r_hold[i] == '0);
        end
        w_acc         = w_edge & ch_mask & {NCH{enable}} & w_hold_zero;
        w_take        = w_acc & (~r_pending | w_grant_vec);
        w_drop        = w_acc & r_pending & ~w_grant_vec;
        w_pending_nxt = (r_pending & ~w_grant_vec) | w_take;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_trig_d     <= '0;
            r_pending    <= '0;
            r_drop_cnt   <= '0;
            r_ev_channel <= '0;
            r_ev_ts      <= '0;
            r_last_grant <= CH_W'(NCH - 1);
            for (int i = 0; i < NCH; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            r_trig_d   <= trigger;
            r_pending  <= w_pending_nxt;
            r_drop_cnt <= sat_add_drops(r_drop_cnt, w_drop);
            if (w_grant) begin
                r_ev_channel <= w_sel;
                r_ev_ts      <= r_ts[w_sel];
            end
            if (w_hs) r_last_grant <= r_ev_channel;
            for (int i = 0; i < NCH; i++) begin
                if (w_take[i]) begin
                    r_hold[i] <= HO_LOAD;
                end else if (!w_hold_zero[i]) begin
                    r_hold[i] <= r_hold[i] - 1'b1;
                end
            end
        end
    end

    // Timestamp capture is data only; it is always written before it is ever granted.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (w_take[i]) r_ts[i] <= timestamp;
        end
    end

    assign ev_valid     = (r_state == S_PRESENT);
    assign ev_channel   = r_ev_channel;
    assign ev_timestamp = r_ev_ts;
    assign pending      = r_pending;
    assign drop_count   = r_drop_cnt;

endmodule

// File: tb/tb_selftrigger_channel_arbiter.sv
// Bench for selftrigger_channel_arbiter: directed scenarios plus random traffic,
// every cycle compared against an event-level reference model.
module tb_selftrigger_channel_arbiter;

    localparam int NCH     = 8;
    localparam int CH_W    = 3;
    localparam int TS_W    = 64;
    localparam int HOLDOFF = 1024;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              enable;
    logic [NCH-1:0]    ch_mask;
    logic [NCH-1:0]    trigger;
    logic [TS_W-1:0]   timestamp;
    logic              ev_valid;
    logic              ev_ready;
    logic [CH_W-1:0]   ev_channel;
    logic [TS_W-1:0]   ev_timestamp;
    logic [NCH-1:0]    pending;
    logic [15:0]       drop_count;

    always #5 clk = ~clk;

    selftrigger_channel_arbiter #(
        .NCH(NCH), .CH_W(CH_W), .TS_W(TS_W), .HOLDOFF(HOLDOFF)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .ch_mask(ch_mask),
        .trigger(trigger), .timestamp(timestamp), .ev_valid(ev_valid),
        .ev_ready(ev_ready), .ev_channel(ev_channel), .ev_timestamp(ev_timestamp),
        .pending(pending), .drop_count(drop_count)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: event queue semantics, holdoff tracked as absolute cycle numbers.
    bit           m_pend  [NCH];
    logic [63:0]  m_ts    [NCH];
    longint       m_acc   [NCH];
    bit           m_trigd [NCH];
    bit           m_valid;
    int           m_chan;
    logic [63:0]  m_evts;
    int           m_last;
    int           m_drop;
    longint       cyc = 0;

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_pend[i]  = 0;
            m_ts[i]    = '0;
            m_acc[i]   = -1000000;
            m_trigd[i] = 0;
        end
        m_valid = 0;
        m_chan  = 0;
        m_evts  = '0;
        m_last  = NCH - 1;
        m_drop  = 0;
    endtask

    task automatic model_step();
        int sel;
        sel = -1;
        if (!m_valid) begin
            for (int k = 1; k <= NCH; k++) begin
                int j;
                j = (m_last + k) % NCH;
                if (sel < 0 && m_pend[j]) sel = j;
            end
        end
        if (m_valid && ev_ready) begin
            m_valid = 0;
            m_last  = m_chan;
        end else if (sel >= 0) begin
            m_valid    = 1;
            m_chan     = sel;
            m_evts     = m_ts[sel];
            m_pend[sel] = 0;
        end
        for (int i = 0; i < NCH; i++) begin
            if (trigger[i] && !m_trigd[i] && enable && ch_mask[i] && (cyc >= m_acc[i] + HOLDOFF)) begin
                if (!m_pend[i]) begin
                    m_pend[i] = 1;
                    m_ts[i]   = timestamp;
                    m_acc[i]  = cyc;
                end else if (m_drop < 65535) begin
                    m_drop++;
                end
            end
            m_trigd[i] = trigger[i];
        end
        cyc++;
    endtask

    function automatic logic [NCH-1:0] model_pend_vec();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_pend[i];
        return v;
    endfunction

    int hs_count;

    task automatic tick();
        if (ev_valid && ev_ready) hs_count++;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_eq("ev_valid", 64'(ev_valid), 64'(m_valid));
        check_eq("ev_channel", 64'(ev_channel), 64'(m_chan));
        check_eq("ev_timestamp", ev_timestamp, m_evts);
        check_eq("pending", 64'(pending), 64'(model_pend_vec()));
        check_eq("drop_count", 64'(drop_count), 64'(m_drop));
        timestamp = timestamp + 1;
    endtask

    // Called at a negedge; asserts reset off-edge and checks the asynchronous clear.
    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rst_ev_valid", 64'(ev_valid), 64'd0);
        check_eq("rst_ev_channel", 64'(ev_channel), 64'd0);
        check_eq("rst_ev_timestamp", ev_timestamp, 64'd0);
        check_eq("rst_pending", 64'(pending), 64'd0);
        check_eq("rst_drop_count", 64'(drop_count), 64'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic pulse(input int ch);
        trigger[ch] = 1'b1;
        tick();
        trigger[ch] = 1'b0;
        tick();
    endtask

    int seen_ch[$];
    int seen_n[$];
    logic [63:0] t_acc;
    int vcount;

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b1;
        ch_mask   = '1;
        trigger   = '0;
        ev_ready  = 1'b0;
        timestamp = '0;
        model_reset();
        hs_count  = 0;
        @(negedge clk);
        do_reset();

        // Single trigger on channel 3
        ev_ready   = 1'b1;
        trigger[3] = 1'b1;
        timestamp  = 64'h100;
        tick();
        check_eq("s1_pend3_set", 64'(pending[3]), 64'd1);
        trigger[3] = 1'b0;
        tick();
        check_eq("s1_valid", 64'(ev_valid), 64'd1);
        check_eq("s1_chan", 64'(ev_channel), 64'd3);
        check_eq("s1_ts", ev_timestamp, 64'h100);
        check_eq("s1_pend3_clr", 64'(pending[3]), 64'd0);
        tick();
        check_eq("s1_done", 64'(ev_valid), 64'd0);

        // Channels 0, 2, 5 together: round-robin order from reset priority
        do_reset();
        ev_ready = 1'b1;
        trigger  = 8'b0010_0101;
        t_acc    = timestamp;
        tick();
        trigger  = '0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (ev_valid) begin
                seen_ch.push_back(int'(ev_channel));
                seen_n.push_back(n);
                check_eq("s2_ts", ev_timestamp, t_acc);
            end
        end
        check_eq("s2_count", 64'(seen_ch.size()), 64'd3);
        if (seen_ch.size() == 3) begin
            check_eq("s2_first", 64'(seen_ch[0]), 64'd0);
            check_eq("s2_second", 64'(seen_ch[1]), 64'd2);
            check_eq("s2_third", 64'(seen_ch[2]), 64'd5);
            check_eq("s2_gap1", 64'(seen_n[1] - seen_n[0]), 64'd2);
            check_eq("s2_gap2", 64'(seen_n[2] - seen_n[1]), 64'd2);
        end

        // Stalled readout: re-triggers on channel 1 after holdoff are dropped
        do_reset();
        ev_ready = 1'b0;
        pulse(1);
        repeat (HOLDOFF) tick();
        pulse(1);
        repeat (HOLDOFF) tick();
        pulse(1);
        pulse(1);
        pulse(1);
        check_eq("s3_drops", 64'(drop_count), 64'd3);
        check_eq("s3_valid", 64'(ev_valid), 64'd1);
        check_eq("s3_chan", 64'(ev_channel), 64'd1);
        check_eq("s3_pending", 64'(pending), 64'h02);
        ev_ready = 1'b1;
        tick();
        check_eq("s3_hs1", 64'(ev_valid), 64'd0);
        tick();
        check_eq("s3_regrant", 64'(ev_valid), 64'd1);
        tick();
        check_eq("s3_drained", 64'(ev_valid | |pending), 64'd0);

        // Long held level and an early re-rise inside holdoff
        do_reset();
        ev_ready   = 1'b1;
        trigger[4] = 1'b1;
        hs_count   = 0;
        tick();
        for (int n = 1; n <= 2000; n++) begin
            if (n == 499) trigger[4] = 1'b0;
            if (n == 500) trigger[4] = 1'b1;
            tick();
        end
        trigger[4] = 1'b0;
        tick();
        check_eq("s4_events", 64'(hs_count), 64'd1);
        check_eq("s4_drops", 64'(drop_count), 64'd0);

        // Masked channel and global disable; queued events still drain
        do_reset();
        ev_ready = 1'b1;
        ch_mask  = 8'hBF;
        hs_count = 0;
        pulse(6);
        repeat (4) tick();
        ch_mask = '1;
        enable  = 1'b0;
        pulse(2);
        repeat (4) tick();
        check_eq("s5_no_events", 64'(hs_count), 64'd0);
        check_eq("s5_no_pending", 64'(pending), 64'd0);
        enable   = 1'b1;
        ev_ready = 1'b0;
        trigger  = 8'b0000_0111;
        tick();
        trigger  = '0;
        tick();
        enable   = 1'b0;
        ev_ready = 1'b1;
        hs_count = 0;
        repeat (10) tick();
        check_eq("s5_drained", 64'(hs_count), 64'd3);
        check_eq("s5_empty", 64'(pending), 64'd0);
        enable = 1'b1;

        // Async reset mid-handshake with three channels pending
        do_reset();
        ev_ready = 1'b0;
        trigger  = 8'b0111_1000;
        tick();
        trigger  = '0;
        tick();
        check_eq("s6_pending", 64'(pending), 64'h70);
        check_eq("s6_valid", 64'(ev_valid), 64'd1);
        do_reset();
        ev_ready = 1'b1;
        vcount   = 0;
        repeat (10) begin
            tick();
            if (ev_valid) vcount++;
        end
        check_eq("s6_silent", 64'(vcount), 64'd0);

        // Random traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(15) == 0) trigger[i] = ~trigger[i];
            end
            if ($urandom_range(7) == 0) ev_ready = ~ev_ready;
            enable = ($urandom_range(31) != 0);
            if ($urandom_range(99) == 0) ch_mask = NCH'($urandom) | 8'hF0;
            if ($urandom_range(199) == 0) timestamp = {$urandom, $urandom};
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/selftrigger_channel_arbiter.md
# selftrigger_channel_arbiter

Collects self-trigger pulses from NCH filter/CFD trigger channels, timestamps each accepted trigger, and schedules the channels one at a time onto a single shared event-readout port. It sits between the per-channel self-trigger filter instances and the record-capture/frame builder. It enforces a per-channel holdoff and counts triggers lost to a still-pending event.

## Interface
- NCH, 8: number of trigger channels (2..40)
- CH_W, 3: width of channel index, ceil(log2(NCH))
- TS_W, 64: timestamp width
- HOLDOFF, 1024: cycles after an accepted trigger during which that channel's new edges are ignored (≥2)

- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  global acceptance enable; low blocks new triggers, draining continues
- ch_mask  in  NCH  per-channel enable; bit low blocks new triggers on that channel
- trigger  in  NCH  trigger levels from filter blocks; may stay high for many cycles
- timestamp  in  TS_W  free-running timestamp
- ev_valid  out  1  event offered to readout
- ev_ready  in  1  readout accepts event
- ev_channel  out  CH_W  channel of offered event
- ev_timestamp  out  TS_W  timestamp latched at that channel's trigger edge
- pending  out  NCH  per-channel event-waiting flags
- drop_count  out  16  saturating count of triggers lost to a pending event

## Operation
- Edge detect: trig_d registers trigger. edge[i] = trigger[i] & ~trig_d[i]. Only rising edges count; a held level is one trigger.
- Accept: edge[i] & enable & ch_mask[i] & (holdoff_cnt[i]==0).
  - Pending[i] clear, or being granted in this cycle: set pending[i], latch ts_reg[i] <= timestamp, load holdoff_cnt[i] <= HOLDOFF-1.
  - Pending[i] set and not being granted: drop. drop_count += 1, saturating at 0xFFFF. Holdoff is not reloaded.
- Holdoff: holdoff_cnt[i] decrements to 0 each cycle. Edges while it is nonzero are ignored silently and are not counted as drops.
- Arbiter FSM, two states:
  - IDLE: if |pending, choose the first set bit scanning round-robin from last_grant+1 (mod NCH). Load ev_channel and ev_timestamp <= ts_reg[sel]. Clear pending[sel], set ev_valid, go to PRESENT. If nothing is pending, stay in IDLE.
  - PRESENT: hold ev_valid, ev_channel and ev_timestamp stable until ev_valid & ev_ready. On that handshake: ev_valid <= 0, last_grant <= ev_channel, go to IDLE.
- Simultaneous grant-clear and new accept on the same channel: the set wins. The new ts_reg value is used by the next grant, and the granted event already holds the old timestamp.
- Deasserting enable or ch_mask does not clear pending. Queued events still drain.
- Channel indices ≥ NCH never appear on ev_channel.

## Timing
- Reset values: ev_valid=0, ev_channel=0, ev_timestamp=0, pending=0, drop_count=0, trig_d=0, holdoff counters=0, FSM=IDLE, last_grant=NCH-1, so channel 0 has first priority.
- A trigger first sampled high at edge t (low at t-1):
  - pending set and timestamp latched at edge t (value present at t).
  - ev_valid high after edge t+1 if the FSM is IDLE.
- Throughput: at most one event per 2 cycles (grant cycle plus handshake cycle). With ev_ready tied high, ev_valid is high for 1 cycle and low for 1 cycle.
- Holdoff: a channel accepted at edge t may accept again from edge t+HOLDOFF.
- ev_ready is ignored while ev_valid=0.
- An async reset mid-handshake drops the offered event and returns to reset values immediately. Outputs are stable from the first clk edge after reset_n rises.

## Test plan
- Reset, then a single rise on trigger[3] with timestamp=0x100 at edge t and ev_ready=1 -> ev_valid at t+1 with ev_channel=3, ev_timestamp=0x100. pending[3] clears at the grant.
- Channels 0, 2 and 5 rise on the same edge, ev_ready=1 -> events in order 0, 2, 5, each 2 cycles apart, all carrying the same timestamp.
- ev_ready=0. Channel 1 is accepted, then re-triggers after HOLDOFF cycles 3 times -> drop_count=3, one event stays offered, and it is delivered when ev_ready=1.
- Channel 4 trigger held high for 2000 cycles with HOLDOFF=1024 -> exactly one event. A second rise 500 cycles after the first accepted one -> ignored, and drop_count is unchanged.
- ch_mask[6]=0 or enable=0 with trigger rises -> no pending, no event. Pending events queued before enable drops are still delivered.
- reset_n pulsed low while ev_valid=1 and 3 bits pending -> all outputs return to reset values asynchronously, and no event is emitted after release without new triggers.
